// File: rtl/alarm_controller.sv
// Anti-theft sequencing FSM with a one-second timebase and a down-counting phase timer.
// Optional build macro SIREN_PULSE_EN: siren pulses 1 s on / 1 s off while in ON.
module alarm_controller #(
    parameter int unsigned CLK_HZ = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       reprogram,
    input  logic [3:0] value,
    output logic [1:0] interval,
    output logic [1:0] fsm_state,
    output logic       status,
    output logic       siren
);

    // state   | meaning
    // SET     | armed, status blinks, watching doors
    // OFF     | disarmed; re-arms after a driver door cycle and T_ARM_DELAY
    // TRIGGER | door opened while armed, waiting for ignition or entry delay
    // ON      | siren active for T_ALARM_ON after doors close
    typedef enum logic [1:0] {
        ST_SET     = 2'd0,
        ST_OFF     = 2'd1,
        ST_TRIGGER = 2'd2,
        ST_ON      = 2'd3
    } state_t;

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic [3:0]    secs;
    logic          timer_active;
    logic          load_pending;
    logic          door_seen;

    logic [1:0]    interval_nxt;
    logic          door_seen_nxt;
    logic          status_nxt;
    logic          siren_nxt;
    logic          start_timer;
    logic          abort_timer;
    logic          hold_reload;
    logic          do_load;
    logic          tick;
    logic          expire;
    logic          any_door;
    logic [3:0]    load_val;

    assign any_door  = door_driver | door_pass;
    assign tick      = (presc == PW'(CLK_HZ - 1));
    assign expire    = timer_active & tick & (secs == 4'd1);
    assign load_val  = (value == 4'd0) ? 4'd1 : value;
    assign do_load   = ~abort_timer & ~start_timer & (load_pending | hold_reload);
    assign fsm_state = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_SET;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        interval_nxt  = interval;
        door_seen_nxt = door_seen;
        start_timer   = 1'b0;
        abort_timer   = 1'b0;
        hold_reload   = 1'b0;
        if (reprogram) begin
            state_nxt     = ST_SET;
            abort_timer   = 1'b1;
            door_seen_nxt = 1'b0;
        end else begin
            case (state)
                ST_SET: begin
                    if (door_driver) begin
                        state_nxt    = ST_TRIGGER;
                        interval_nxt = 2'b01;
                        start_timer  = 1'b1;
                    end else if (door_pass) begin
                        state_nxt    = ST_TRIGGER;
                        interval_nxt = 2'b10;
                        start_timer  = 1'b1;
                    end
                end
                ST_TRIGGER: begin
                    if (ignition) begin
                        state_nxt   = ST_OFF;
                        abort_timer = 1'b1;
                    end else if (expire) begin
                        state_nxt    = ST_ON;
                        interval_nxt = 2'b11;
                        start_timer  = 1'b1;
                    end
                end
                ST_ON: begin
                    if (ignition) begin
                        state_nxt   = ST_OFF;
                        abort_timer = 1'b1;
                    end else if (any_door) begin
                        hold_reload = 1'b1;
                    end else if (expire) begin
                        state_nxt = ST_SET;
                    end
                end
                ST_OFF: begin
                    if (ignition) begin
                        door_seen_nxt = 1'b0;
                        abort_timer   = 1'b1;
                    end else begin
                        if (door_driver) begin
                            door_seen_nxt = 1'b1;
                        end
                        // an open door cancels a running arm delay; it restarts in full on close
                        if (any_door) begin
                            abort_timer = 1'b1;
                        end else if (expire) begin
                            state_nxt     = ST_SET;
                            door_seen_nxt = 1'b0;
                        end else if (door_seen && !timer_active && !load_pending) begin
                            interval_nxt = 2'b00;
                            start_timer  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_SET;
                end
            endcase
        end
    end

    // value follows interval combinationally, so the count is captured one edge after interval changes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc        <= '0;
            secs         <= 4'd0;
            timer_active <= 1'b0;
            load_pending <= 1'b0;
            door_seen    <= 1'b0;
        end else begin
            door_seen <= door_seen_nxt;
            if (do_load || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
            if (abort_timer) begin
                timer_active <= 1'b0;
                load_pending <= 1'b0;
                secs         <= 4'd0;
            end else if (start_timer) begin
                timer_active <= 1'b0;
                load_pending <= 1'b1;
            end else if (do_load) begin
                secs         <= load_val;
                timer_active <= 1'b1;
                load_pending <= 1'b0;
            end else if (expire) begin
                timer_active <= 1'b0;
                secs         <= 4'd0;
            end else if (timer_active && tick) begin
                secs <= secs - 4'd1;
            end
        end
    end

    always_comb begin
        status_nxt = 1'b0;
        siren_nxt  = 1'b0;
        case (state_nxt)
            ST_SET: begin
                status_nxt = (state == ST_SET && !reprogram) ? (status ^ tick) : 1'b0;
            end
            ST_TRIGGER: begin
                status_nxt = 1'b1;
            end
            ST_ON: begin
                status_nxt = 1'b1;
`ifdef SIREN_PULSE_EN
                siren_nxt  = (state == ST_ON) ? (siren ^ tick) : 1'b1;
`else
                siren_nxt  = 1'b1;
`endif
            end
            default: begin
                status_nxt = 1'b0;
                siren_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            interval <= 2'b00;
            status   <= 1'b0;
            siren    <= 1'b0;
        end else begin
            interval <= interval_nxt;
            status   <= status_nxt;
            siren    <= siren_nxt;
        end
    end

endmodule
